// File: rtl/keypad_pkg.sv
// Shared keypad definitions: code width, default FIFO depth and the key code
// type used by both the scanner and the key buffer.
package keypad_pkg;

  localparam int CODE_W     = 4;
  localparam int FIFO_DEPTH = 8;

  typedef logic [CODE_W-1:0] key_code_t;

endpackage

// File: rtl/hex_key_buffer_if.sv
// Bus between the keypad key buffer and its host: scanner input, FIFO drain
// port, status flags and the hex entry register.
interface hex_key_buffer_if
  import keypad_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int DIGITS = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // valid is a level, and only its rising edge is a key event (code is
  // sampled then). rd_en pops the head only when !empty. rd_data is
  // fall-through and keeps the last head value while empty.
  logic                  valid;
  key_code_t             code;
  logic                  rd_en;
  logic                  clr_ovf;
  logic                  clr_digits;
  key_code_t             rd_data;
  logic                  empty;
  logic                  full;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic [4*DIGITS-1:0]   digits;

  modport master (
    output valid, code, rd_en, clr_ovf, clr_digits,
    input  rd_data, empty, full, count, overflow, digits
  );

  modport slave (
    input  valid, code, rd_en, clr_ovf, clr_digits,
    output rd_data, empty, full, count, overflow, digits
  );

endinterface

// File: rtl/keypad_fifo.sv
// Synchronous first-word-fall-through FIFO with a separate occupancy counter,
// so full and empty never depend on pointer comparison.
module keypad_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = CODE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     rd_data_q, rd_data_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop    = pop && (count_q != '0);
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    do_push   = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d  = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - CNT_W'(1);

    rd_data_d = rd_data_q;
    if (do_pop && (count_q > CNT_W'(1))) begin
      rd_data_d = mem_q[rd_ptr_q + PTR_W'(1)];
    end else if (do_push && ((count_q == '0) || (do_pop && (count_q == CNT_W'(1))))) begin
      rd_data_d = wr_data;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/hex_key_buffer.sv
// Turns the scanner's level valid/code into single key events, queues them in
// a FWFT FIFO and shifts them into a hex entry register for the display.
module hex_key_buffer
  import keypad_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  hex_key_buffer_if.slave   bus
);

  localparam int DW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] digits_q, digits_d;
  logic [DW-1:0] digits_base;
  logic          key_event;
  logic          drop;

  key_code_t        fifo_rd_data;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  keypad_fifo #(
    .DEPTH (DEPTH),
    .W     (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (key_event),
    .pop     (bus.rd_en),
    .wr_data (bus.code),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    valid_d   = bus.valid;
    key_event = bus.valid && !valid_q;
    // Full implies non-empty, so any rd_en here is a real pop that makes room.
    drop      = key_event && fifo_full && !bus.rd_en;

    overflow_d = overflow_q;
    if (bus.clr_ovf) overflow_d = 1'b0;
    if (drop)        overflow_d = 1'b1;

    digits_base = bus.clr_digits ? '0 : digits_q;
    digits_d    = key_event ? {digits_base[DW-5:0], bus.code} : digits_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b1;
      overflow_q <= 1'b0;
      digits_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      digits_q   <= digits_d;
    end
  end

  assign bus.rd_data  = fifo_rd_data;
  assign bus.count    = fifo_count;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.overflow = overflow_q;
  assign bus.digits   = digits_q;

endmodule

// File: tb/tb_hex_key_buffer.sv
// Bench for hex_key_buffer: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_hex_key_buffer;

  localparam int DEPTH  = 8;
  localparam int DIGITS = 4;
  localparam int DW     = 4 * DIGITS;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  hex_key_buffer_if #(.DEPTH(DEPTH), .DIGITS(DIGITS)) bus ();

  hex_key_buffer #(.DEPTH(DEPTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: a queue of codes, digits as base-16 arithmetic
  logic [3:0] exp_q[$];
  logic [3:0] mdl_rd;
  logic       mdl_prev;
  logic       mdl_ovf;
  longint     mdl_digits;

  always @(posedge clk) begin
    logic ev;
    logic drop;
    ev   = 1'b0;
    drop = 1'b0;
    if (rst) begin
      exp_q.delete();
      mdl_rd     = '0;
      mdl_prev   = 1'b1;
      mdl_ovf    = 1'b0;
      mdl_digits = 0;
    end else begin
      ev       = bus.valid && !mdl_prev;
      mdl_prev = bus.valid;
      if (bus.rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
      if (ev) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(bus.code);
        else drop = 1'b1;
      end
      if (bus.clr_ovf) mdl_ovf = 1'b0;
      if (drop) mdl_ovf = 1'b1;
      if (bus.clr_digits) mdl_digits = 0;
      if (ev) mdl_digits = (mdl_digits * 16 + longint'(bus.code)) % (longint'(1) << DW);
      if (exp_q.size() > 0) mdl_rd = exp_q[0];
    end
    #1;
    check("m_rd_data", 32'(bus.rd_data), 32'(mdl_rd));
    check("m_count", 32'(bus.count), 32'(exp_q.size()));
    check("m_empty", 32'(bus.empty), 32'(exp_q.size() == 0));
    check("m_full", 32'(bus.full), 32'(exp_q.size() == DEPTH));
    check("m_overflow", 32'(bus.overflow), 32'(mdl_ovf));
    check("m_digits", 32'(bus.digits), 32'(mdl_digits));
  end

  // driver tasks (inputs change on the falling edge)
  task automatic press(input logic [3:0] c, input int hi, input int lo);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.code  = c;
    repeat (hi) @(negedge clk);
    bus.valid = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    logic [3:0] heads [8];
    logic [3:0] last;
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.valid      = 1'b0;
    bus.code       = '0;
    bus.rd_en      = 1'b0;
    bus.clr_ovf    = 1'b0;
    bus.clr_digits = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_digits", 32'(bus.digits), 0);
    rst = 1'b0;

    // single press held 10 cycles
    press(4'hA, 10, 3);
    check("single_count", 32'(bus.count), 1);
    check("single_rd", 32'(bus.rd_data), 32'hA);
    check("single_digits", 32'(bus.digits), 32'h000A);
    pop();

    // sequence and drain
    for (int i = 1; i <= 4; i++) press(4'(i), 5, 3);
    check("seq_digits", 32'(bus.digits), 32'h1234);
    for (int i = 1; i <= 4; i++) begin
      check("seq_head", 32'(bus.rd_data), 32'(i));
      pop();
    end
    check("seq_empty", 32'(bus.empty), 1);
    pop();
    check("extra_pop_count", 32'(bus.count), 0);
    check("extra_pop_rd", 32'(bus.rd_data), 32'h4);

    // overflow with codes 0..8
    for (int i = 0; i <= 8; i++) press(4'(i), 2, 2);
    check("ovf_full", 32'(bus.full), 1);
    check("ovf_count", 32'(bus.count), 8);
    check("ovf_flag", 32'(bus.overflow), 1);
    check("ovf_digits", 32'(bus.digits), 32'h5678);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    check("ovf_cleared", 32'(bus.overflow), 0);

    // full: event and pop in the same cycle
    bus.valid = 1'b1;
    bus.code  = 4'hF;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    @(negedge clk);
    bus.valid = 1'b0;
    @(negedge clk);
    check("fullpp_count", 32'(bus.count), 8);
    check("fullpp_ovf", 32'(bus.overflow), 0);
    heads = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF};
    last  = '0;
    for (int i = 0; i < 8; i++) begin
      check("fullpp_head", 32'(bus.rd_data), 32'(heads[i]));
      last = bus.rd_data;
      pop();
    end
    check("fullpp_last", 32'(last), 32'hF);

    // event together with clr_digits
    bus.valid      = 1'b1;
    bus.code       = 4'h7;
    bus.clr_digits = 1'b1;
    @(negedge clk);
    bus.clr_digits = 1'b0;
    bus.valid      = 1'b0;
    @(negedge clk);
    check("clr_ev_digits", 32'(bus.digits), 32'h0007);

    // reset mid-stream with the key held
    bus.valid = 1'b1;
    bus.code  = 4'h3;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_count", 32'(bus.count), 0);
    check("midrst_rd", 32'(bus.rd_data), 0);
    check("midrst_digits", 32'(bus.digits), 0);
    bus.valid = 1'b0;
    @(negedge clk);
    bus.valid = 1'b1;
    bus.code  = 4'h9;
    @(negedge clk);
    check("midrst_repress", 32'(bus.rd_data), 32'h9);
    bus.valid = 1'b0;
    @(negedge clk);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.valid      = ($urandom_range(0, 2) != 0) ? ~bus.valid : bus.valid;
      bus.code       = 4'($urandom_range(0, 15));
      bus.rd_en      = ($urandom_range(0, 3) == 0);
      bus.clr_ovf    = ($urandom_range(0, 15) == 0);
      bus.clr_digits = ($urandom_range(0, 31) == 0);
      rst            = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.valid = 1'b0;
    bus.rd_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
